// File: rtl/simon_pipe_ctrl_if.sv
// Block stream interface of the Simon32/64 pipeline controller: plaintext in,
// ciphertext out, each direction with a valid/ready handshake and a user tag.
interface simon_pipe_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/simon_pipe_ctrl.sv
// Sequencing controller for the unrolled Simon32/64 pipeline: tracks per-stage
// validity and tags, stalls the whole pipe on backpressure, and owns key changes.
module simon_pipe_ctrl #(
  parameter int DEPTH   = 32,
  parameter int KEY_CYC = 32,
  parameter int TAG_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [63:0]                 key_in,
  input  logic                        key_load,
  output logic                        key_busy,
  simon_pipe_ctrl_if.slave            bus,
  output logic [$clog2(DEPTH+2)-1:0]  occ,
  output logic                        pipe_start,
  output logic [63:0]                 pipe_key,
  output logic [31:0]                 pipe_pt,
  input  logic [31:0]                 pipe_ct
);

  localparam int OCC_W = $clog2(DEPTH+2);
  localparam int CNT_W = $clog2(KEY_CYC+1);

  typedef enum logic [1:0] {NOKEY, KEYLD, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [DEPTH:0]   vld;
  logic [TAG_W-1:0] tag [DEPTH+1];
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [63:0]      key_pend, key_pend_nxt, pipe_key_nxt;
  logic [OCC_W-1:0] occ_nxt;
  logic             adv, acc, xfer;

  assign adv        = (state == RUN || state == DRAIN) && (!vld[DEPTH] || bus.out_ready);
  assign pipe_start = adv || state == KEYLD;
  assign bus.in_ready = (state == RUN) && adv && !key_load;
  assign acc        = bus.in_valid && bus.in_ready;
  assign xfer       = vld[DEPTH] && bus.out_ready;
  assign occ_nxt    = occ + OCC_W'(acc) - OCC_W'(xfer);
  assign key_busy   = state != RUN;
  assign pipe_pt    = bus.in_data;
  assign bus.out_valid = vld[DEPTH];
  assign bus.out_data  = pipe_ct;
  assign bus.out_tag   = tag[DEPTH];

  // Key changes only happen with an empty pipe, so pipe_key never moves under a valid block.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    key_pend_nxt = key_pend;
    pipe_key_nxt = pipe_key;
    unique case (state)
      NOKEY: begin
        if (key_load) begin
          pipe_key_nxt = key_in;
          cnt_nxt      = '0;
          state_nxt    = KEYLD;
        end
      end
      KEYLD: begin
        if (key_load) begin
          pipe_key_nxt = key_in;
          cnt_nxt      = '0;
        end else if (cnt == CNT_W'(KEY_CYC-1)) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (key_load) begin
          if (occ == '0) begin
            pipe_key_nxt = key_in;
            cnt_nxt      = '0;
            state_nxt    = KEYLD;
          end else begin
            key_pend_nxt = key_in;
            state_nxt    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (key_load) key_pend_nxt = key_in;
        if (occ_nxt == '0) begin
          pipe_key_nxt = key_load ? key_in : key_pend;
          cnt_nxt      = '0;
          state_nxt    = KEYLD;
        end
      end
      default: state_nxt = NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= NOKEY;
      cnt      <= '0;
      key_pend <= '0;
      pipe_key <= '0;
      occ      <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      key_pend <= key_pend_nxt;
      pipe_key <= pipe_key_nxt;
      occ      <= occ_nxt;
    end
  end

  // Validity and tags move only together with the pipeline's advance enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i <= DEPTH; i++) tag[i] <= '0;
    end else if (adv) begin
      vld    <= {vld[DEPTH-1:0], acc};
      tag[0] <= bus.in_tag;
      for (int i = 1; i <= DEPTH; i++) tag[i] <= tag[i-1];
    end
  end

endmodule

// File: tb/tb_simon_pipe_ctrl.sv
// Self-checking bench: emulates the Simon pipeline around the controller and
// compares every output against a queue of reference encryptions.
module tb_simon_pipe_ctrl;

  localparam int DEPTH   = 32;
  localparam int KEY_CYC = 32;
  localparam int TAG_W   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] key_in = '0;
  logic        key_load = 1'b0;
  logic        key_busy;
  logic [5:0]  occ;
  logic        pipe_start;
  logic [63:0] pipe_key;
  logic [31:0] pipe_pt;
  logic [31:0] pipe_ct;

  simon_pipe_ctrl_if #(.TAG_W(TAG_W)) bus ();

  simon_pipe_ctrl #(.DEPTH(DEPTH), .KEY_CYC(KEY_CYC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_busy(key_busy),
    .bus(bus), .occ(occ), .pipe_start(pipe_start), .pipe_key(pipe_key),
    .pipe_pt(pipe_pt), .pipe_ct(pipe_ct)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Straight Simon32/64 encryption, used both by the pipe emulator and the reference queue.
  function automatic logic [31:0] simon_enc(input logic [31:0] pt, input logic [63:0] key);
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    logic [61:0] zc;
    zc = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
      t = t ^ {t[0], t[15:1]};
      k[i] = ~k[i-4] ^ t ^ {15'b0, zc[61-(i-4)]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Pipeline emulator: DEPTH plaintext holding stages feeding a ciphertext register.
  logic [31:0] ps [DEPTH];
  logic [31:0] pct = '0;
  assign pipe_ct = pct;
  initial for (int i = 0; i < DEPTH; i++) ps[i] = '0;

  always @(posedge clk) begin
    if (pipe_start) begin
      ps[0] <= pipe_pt;
      for (int i = 1; i < DEPTH; i++) ps[i] <= ps[i-1];
      pct <= simon_enc(ps[DEPTH-1], pipe_key);
    end
  end

  // Reference: every accepted block is encrypted under the most recently requested key.
  logic [35:0] q [$];
  logic [63:0] cur_key = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;
  logic [35:0] exp_item;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      checkOutput("occ_model", 64'(occ), 64'(q.size()));
      if (bus.out_valid && !bus.out_ready) checkOutput("stall_start", 64'(pipe_start), 0);
      if (stall_prev) begin
        checkOutput("stall_data", 64'(bus.out_data), 64'(prev_data));
        checkOutput("stall_tag", 64'(bus.out_tag), 64'(prev_tag));
      end
      if (key_busy) checkOutput("busy_ready", 64'(bus.in_ready), 0);
      if (bus.in_valid && bus.in_ready) q.push_back({simon_enc(bus.in_data, cur_key), bus.in_tag});
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checkOutput("spurious_out", 64'(bus.out_valid), 0);
        end else begin
          exp_item = q.pop_front();
          checkOutput("out_data", 64'(bus.out_data), 64'(exp_item[35:4]));
          checkOutput("out_tag", 64'(bus.out_tag), 64'(exp_item[3:0]));
        end
      end
      if (key_load) cur_key = key_in;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_tag   = bus.out_tag;
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] t,
                               input logic ordy, input logic kl, input logic [63:0] k);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    key_load      = kl;
    key_in        = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 32'h0, 4'h0, ordy, 1'b0, 64'h0);
  endtask

  task automatic wait_key_ready(input string name);
    int n = 0;
    while (key_busy && n < 300) begin
      idle(1'b1);
      n++;
    end
    checkOutput(name, 64'(key_busy), 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || occ != 0) && n < 300) begin
      idle(1'b1);
      n++;
    end
    checkOutput(name, 64'(occ), 0);
  endtask

  int n;
  int max_occ;
  logic [63:0] key2, key3;

  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.in_tag = 0; bus.out_ready = 0;
    #12;
    checkOutput("rst_busy", 64'(key_busy), 1);
    checkOutput("rst_ready", 64'(bus.in_ready), 0);
    checkOutput("rst_oval", 64'(bus.out_valid), 0);
    checkOutput("rst_start", 64'(pipe_start), 0);
    checkOutput("rst_pkey", pipe_key, 0);
    checkOutput("rst_occ", 64'(occ), 0);
    checkOutput("rst_otag", 64'(bus.out_tag), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1'b1);

    // Known-answer vector and key settle time
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 64'h1918_1110_0908_0100);
    n = 0;
    while (key_busy && n < 100) begin
      idle(1'b1);
      n++;
    end
    checkOutput("busy_cycles", 64'(n), 32);
    checkOutput("kat_ready", 64'(bus.in_ready), 1);
    applyStimulus(1'b1, 32'h6565_6877, 4'h5, 1'b1, 1'b0, 64'h0);
    checkOutput("kat_occ1", 64'(occ), 1);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      idle(1'b1);
      n++;
    end
    checkOutput("kat_latency", 64'(n), 33);
    checkOutput("kat_data", 64'(bus.out_data), 64'h c69b_e9bb);
    checkOutput("kat_tag", 64'(bus.out_tag), 5);
    idle(1'b1);
    checkOutput("kat_occ0", 64'(occ), 0);

    // Back-to-back stream
    max_occ = 0;
    for (int i = 0; i < 40; i++) begin
      checkOutput("b2b_ready", 64'(bus.in_ready), 1);
      applyStimulus(1'b1, $urandom, 4'(i % 16), 1'b1, 1'b0, 64'h0);
      if (int'(occ) > max_occ) max_occ = int'(occ);
    end
    drain("b2b_drain");
    checkOutput("b2b_peak", 64'(max_occ), 33);

    // Full pipe under backpressure
    n = 0;
    while (bus.in_ready && n < 100) begin
      applyStimulus(1'b1, $urandom, 4'(n), 1'b0, 1'b0, 64'h0);
      n++;
    end
    checkOutput("full_count", 64'(n), 33);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      checkOutput("full_ready", 64'(bus.in_ready), 0);
      checkOutput("full_start", 64'(pipe_start), 0);
      checkOutput("full_occ", 64'(occ), 33);
    end
    drain("full_drain");

    // Key change with blocks in flight, second request during the drain
    key2 = {$urandom, $urandom};
    key3 = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom, 4'(i), 1'b1, 1'b0, 64'h0);
    bus.in_valid = 1'b1;
    key_load = 1'b1;
    key_in = key2;
    #1;
    checkOutput("kl_ready_same", 64'(bus.in_ready), 0);
    @(posedge clk); #1;
    key_load = 1'b0;
    checkOutput("kl_ready_next", 64'(bus.in_ready), 0);
    checkOutput("kl_occ", 64'(occ), 5);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 4'h0, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, $urandom, 4'h0, 1'b1, 1'b1, key3);
    checkOutput("drain_busy", 64'(key_busy), 1);
    wait_key_ready("kl_settle");
    checkOutput("kl_pkey", pipe_key, key3);
    applyStimulus(1'b1, $urandom, 4'hA, 1'b1, 1'b0, 64'h0);
    drain("kl_newkey");

    // Async reset mid-stream
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, $urandom, 4'(i), 1'b1, 1'b0, 64'h0);
    checkOutput("pre_rst_occ", 64'(occ), 12);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_occ", 64'(occ), 0);
    checkOutput("arst_oval", 64'(bus.out_valid), 0);
    checkOutput("arst_ready", 64'(bus.in_ready), 0);
    checkOutput("arst_busy", 64'(key_busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, $urandom, 4'h0, 1'b1, 1'b0, 64'h0);
    checkOutput("post_rst_oval", 64'(bus.out_valid), 0);
    checkOutput("post_rst_busy", 64'(key_busy), 1);

    // Randomized traffic with occasional rekeying
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, {$urandom, $urandom});
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, 4'($urandom), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 199) == 0, {$urandom, $urandom});
    end
    wait_key_ready("rnd_settle");
    drain("rnd_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_pipe_ctrl.md
Name: simon_pipe_ctrl

Overview:
Sequencing controller wrapped around the 32-round unrolled Simon32/64 encryption pipeline and its key-schedule generator. Provides a valid/ready block interface with per-block tags and tracks slot validity through every pipeline stage. Drives the pipeline's global advance enable and stalls the whole pipe on output backpressure. Owns key loading: it drains in-flight blocks before installing a new key and waits out the key-schedule settle time.

Parameters:
DEPTH, 32, round stages in the pipeline; total register stages = DEPTH+1 (input reg + DEPTH rounds, last round feeding output reg)
KEY_CYC, 32, cycles pipe_start is held with a stable key for the key schedule to settle (>=1)
TAG_W, 4, width of the user tag carried alongside each block

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
key_in  in  64  new master key
key_load  in  1  single-cycle key install request
key_busy  out  1  high when not in RUN
in_valid  in  1  plaintext block offered
in_ready  out  1  block accepted when in_valid && in_ready
in_data  in  32  plaintext
in_tag  in  TAG_W  user tag
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts
out_data  out  32  ciphertext from pipe_ct
out_tag  out  TAG_W  tag of the block on out_data
occ  out  $clog2(DEPTH+2)  blocks in flight, including output reg
pipe_start  out  1  pipeline/key-schedule advance enable
pipe_key  out  64  key to key schedule
pipe_pt  out  32  plaintext to pipeline stage 1
pipe_ct  in  32  ciphertext output reg of pipeline

Behaviour:
- Reset (async, rst=0): state=NOKEY; vld[DEPTH:0]=0; occ=0; key_busy=1; in_ready=0; out_valid=0; pipe_start=0; pipe_key=0; out_tag=0. Tag shift regs need not be reset.
- vld[i] marks pipeline stage i (0 = input reg, DEPTH = ciphertext reg) holding a real block. tag[i] shifts in lockstep.
- out_valid = vld[DEPTH]; out_data = pipe_ct; out_tag = tag[DEPTH].
- adv = (state==RUN || state==DRAIN) && (!vld[DEPTH] || out_ready).
- pipe_start = adv || state==KEYLD.
- in_ready = (state==RUN) && adv && !key_load.
- pipe_pt = in_data (combinational).
- On adv: vld[0] <= in_valid && in_ready; vld[i] <= vld[i-1]; tag[0] <= in_tag; tag[i] <= tag[i-1].
- No adv: vld/tag hold. A stall freezes the entire pipe, so out_data stays stable while out_valid && !out_ready.
- Latency: a block accepted at edge t appears with out_valid after DEPTH+1 advancing edges (33 with defaults). Throughput is 1 block/cycle when unstalled. Order is preserved.
- occ: +1 on accept, -1 on output transfer (out_valid && out_ready), unchanged when both or neither occur. occ == popcount(vld).
- FSM:
  - NOKEY: key_load -> latch key_in into pipe_key, cnt=0, go KEYLD.
  - KEYLD: cnt++. When cnt==KEY_CYC-1, go RUN. A key_load here latches the new key and restarts cnt=0. vld is all-zero throughout, so garbage shifted through the pipe is never flagged valid.
  - RUN: key_load with occ==0 -> latch key, cnt=0, KEYLD. key_load with occ!=0 -> latch key_in into key_pend, go DRAIN. in_ready is already 0 in the key_load cycle.
  - DRAIN: in_ready=0, bubbles shift in, outputs still delivered under the old key. When occ reaches 0 (including the cycle the last output transfers, i.e. next occ==0) -> pipe_key<=key_pend, cnt=0, KEYLD. A further key_load in DRAIN overwrites key_pend; last request wins.
- pipe_key changes only on entry to KEYLD, never while any vld bit is set.
- Reset mid-operation discards all in-flight blocks with no output. A key is required again after reset.

Test Plan:
1. Reset; key_load with key_in=64'h1918_1110_0908_0100 -> key_busy=1 for exactly 32 cycles, then 0. Send in_data=32'h6565_6877 tag 4'h5 -> out_valid exactly 33 advancing edges later with out_data=32'hc69b_e9bb, out_tag=4'h5; occ 1 then 0.
2. 40 back-to-back blocks (tags 0..F cycling), out_ready=1 -> outputs on 40 consecutive cycles, tags in order, occ peaks at 33, in_ready never drops.
3. Pipe full, out_ready=0 for 10 cycles -> in_ready=0 and pipe_start=0 throughout, out_data/out_tag stable, occ=33. Release -> all 33 outputs delivered, no loss or duplicate.
4. 5 blocks in flight, key_load with new key -> in_ready=0 next cycle, 5 outputs with old-key ciphertext, then 32 cycles of key_busy with new pipe_key. The next block encrypts under the new key. A second key_load during DRAIN -> the second key is installed.
5. Async rst pulse mid-stream (occ=12) -> out_valid, occ, in_ready = 0 and key_busy=1 immediately without a clock edge. After release, no stale outputs appear even after 40 cycles with no key_load.
